// File: rtl/z8_fetch_unit_if.sv
// Fetch unit bus bundle: program-memory read port, jump redirect and the
// instruction valid/ready channel towards execute.
interface z8_fetch_unit_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] memAddr;
    logic              memStrobe;
    logic [7:0]        memDataRead;
    logic              redirectEn;
    logic [ADDR_W-1:0] redirectAddr;
    logic              instrValid;
    logic              instrReady;
    logic [1:0]        instrLen;
    logic [7:0]        instrByte0;
    logic [7:0]        instrByte1;
    logic [7:0]        instrByte2;
    logic [ADDR_W-1:0] instrPc;
    logic [ADDR_W-1:0] instrNextPc;

    modport master (
        output memAddr,
        output memStrobe,
        input  memDataRead,
        input  redirectEn,
        input  redirectAddr,
        output instrValid,
        input  instrReady,
        output instrLen,
        output instrByte0,
        output instrByte1,
        output instrByte2,
        output instrPc,
        output instrNextPc
    );

    modport slave (
        input  memAddr,
        input  memStrobe,
        output memDataRead,
        output redirectEn,
        output redirectAddr,
        input  instrValid,
        output instrReady,
        input  instrLen,
        input  instrByte0,
        input  instrByte1,
        input  instrByte2,
        input  instrPc,
        input  instrNextPc
    );
endinterface

// File: rtl/z8_fetch_unit.sv
// Prefetching instruction fetch unit: streams program bytes into a tagged byte
// FIFO and assembles 1/2/3-byte instructions for execute over valid/ready.
module z8_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 4
) (
    input  logic            clk,
    input  logic            resetN,
    z8_fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] tag;
        logic [7:0]        data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_B1,
        S_B2,
        S_DONE
    } asm_state_e;

    // Opcode low nibble selects the instruction length.
    function automatic logic [1:0] decode_len(input logic [3:0] nib);
        logic [1:0] len;
        if (nib[3:1] == 3'b111) begin
            len = 2'd1;
        end else if ((nib[3:2] == 2'b01) || (nib == 4'hD)) begin
            len = 2'd3;
        end else begin
            len = 2'd2;
        end
        return len;
    endfunction

    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              in_flight_q, in_flight_d;
    logic [ADDR_W-1:0] in_flight_tag_q, in_flight_tag_d;

    fifo_entry_t       fifo_mem_q [DEPTH];
    fifo_entry_t       fifo_mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    asm_state_e        state_q, state_d;
    logic [1:0]        len_q, len_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [7:0]        byte1_q, byte1_d;
    logic [7:0]        byte2_q, byte2_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;

    logic              strobe_c;
    logic              push_c;
    logic              pop_c;
    logic              fifo_empty_c;
    logic              instr_valid_c;
    fifo_entry_t       head_c;
    logic [1:0]        op_len_c;

    // Credit rule: bytes buffered plus the byte in flight never exceed DEPTH.
    assign strobe_c      = resetN & ~bus.redirectEn &
                           ((count_q + CNT_W'(in_flight_q)) < CNT_W'(DEPTH));
    assign fifo_empty_c  = (count_q == '0);
    assign instr_valid_c = (state_q == S_DONE);
    assign head_c        = fifo_mem_q[rd_ptr_q];
    assign push_c        = in_flight_q & ~bus.redirectEn;
    assign pop_c         = ~fifo_empty_c & (~instr_valid_c | bus.instrReady) & ~bus.redirectEn;
    assign op_len_c      = decode_len(head_c.data[3:0]);

    // Fetch address sequencing and in-flight tracking.
    always_comb begin
        fetch_addr_d    = fetch_addr_q;
        in_flight_d     = strobe_c;
        in_flight_tag_d = in_flight_tag_q;
        if (bus.redirectEn) begin
            fetch_addr_d = bus.redirectAddr;
        end else if (strobe_c) begin
            fetch_addr_d    = fetch_addr_q + ADDR_W'(1);
            in_flight_tag_d = fetch_addr_q;
        end
    end

    // Byte FIFO; a redirect flushes it and drops the returning byte.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus.redirectEn) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                fifo_mem_d[wr_ptr_q] = '{tag: in_flight_tag_q, data: bus.memDataRead};
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Instruction assembler; a pop in DONE happens only on a handshake and
    // loads the next opcode on that same edge.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        byte0_d   = byte0_q;
        byte1_d   = byte1_q;
        byte2_d   = byte2_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        if (pop_c) begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    len_d     = op_len_c;
                    byte0_d   = head_c.data;
                    byte1_d   = 8'h00;
                    byte2_d   = 8'h00;
                    pc_d      = head_c.tag;
                    next_pc_d = head_c.tag + ADDR_W'(op_len_c);
                    state_d   = (op_len_c == 2'd1) ? S_DONE : S_B1;
                end
                S_B1: begin
                    byte1_d = head_c.data;
                    state_d = (len_q == 2'd3) ? S_B2 : S_DONE;
                end
                S_B2: begin
                    byte2_d = head_c.data;
                    state_d = S_DONE;
                end
            endcase
        end else if (instr_valid_c && bus.instrReady) begin
            state_d = S_IDLE;
        end
        if (bus.redirectEn) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fetch_addr_q    <= RESET_PC;
            in_flight_q     <= 1'b0;
            in_flight_tag_q <= '0;
            fifo_mem_q      <= '{default: '0};
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            state_q         <= S_IDLE;
            len_q           <= 2'd0;
            byte0_q         <= 8'h00;
            byte1_q         <= 8'h00;
            byte2_q         <= 8'h00;
            pc_q            <= RESET_PC;
            next_pc_q       <= RESET_PC;
        end else begin
            fetch_addr_q    <= fetch_addr_d;
            in_flight_q     <= in_flight_d;
            in_flight_tag_q <= in_flight_tag_d;
            fifo_mem_q      <= fifo_mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            state_q         <= state_d;
            len_q           <= len_d;
            byte0_q         <= byte0_d;
            byte1_q         <= byte1_d;
            byte2_q         <= byte2_d;
            pc_q            <= pc_d;
            next_pc_q       <= next_pc_d;
        end
    end

    assign bus.memAddr     = fetch_addr_q;
    assign bus.memStrobe   = strobe_c;
    assign bus.instrValid  = instr_valid_c;
    assign bus.instrLen    = len_q;
    assign bus.instrByte0  = byte0_q;
    assign bus.instrByte1  = byte1_q;
    assign bus.instrByte2  = byte2_q;
    assign bus.instrPc     = pc_q;
    assign bus.instrNextPc = next_pc_q;
endmodule

// File: tb/tb_z8_fetch_unit.sv
// Bench for z8_fetch_unit: directed vector table, multi-cycle corner cases and
// a randomized run against an instruction-stream reference model.
module tb_z8_fetch_unit;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DEPTH    = 4;
    localparam logic [7:0]  RESET_PC = 8'h00;

    typedef struct {
        logic [7:0] pc;
        int         len;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] npc;
    } vec_t;

    logic       clk    = 1'b0;
    logic       resetN = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] rdata  = 8'h00;
    int         strobes = 0;
    int         checks  = 0;
    int         errors  = 0;
    int         len_tab [16] = '{2, 2, 2, 2, 3, 3, 3, 3, 2, 2, 2, 2, 2, 3, 1, 1};
    vec_t       vecs [12];

    z8_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    z8_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data registered on the strobe edge.
    always @(posedge clk) begin
        if (bus.memStrobe) begin
            rdata   <= mem[bus.memAddr];
            strobes <= strobes + 1;
        end
    end
    assign bus.memDataRead = rdata;

    initial begin
        #500000;
        $display("FAIL watchdog expired act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: act=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_len(input logic [7:0] p);
        return len_tab[mem[p][3:0]];
    endfunction

    // Compare the presented instruction with the one the model expects at p.
    task automatic check_instr(input logic [7:0] p);
        int         l;
        logic [7:0] a1;
        logic [7:0] a2;
        l  = exp_len(p);
        a1 = p + 8'd1;
        a2 = p + 8'd2;
        check("len", 32'(bus.instrLen), l);
        check("byte0", 32'(bus.instrByte0), 32'(mem[p]));
        check("byte1", 32'(bus.instrByte1), (l >= 2) ? 32'(mem[a1]) : 32'h0);
        check("byte2", 32'(bus.instrByte2), (l == 3) ? 32'(mem[a2]) : 32'h0);
        check("pc", 32'(bus.instrPc), 32'(p));
        check("next_pc", 32'(bus.instrNextPc), 32'(8'(p + 8'(l))));
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (!bus.instrValid && n < budget) begin
            tick();
            n++;
        end
        if (!bus.instrValid) check(name, 32'(bus.instrValid), 32'h1);
    endtask

    task automatic run_stream(input logic [7:0] start, input int n);
        logic [7:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            wait_valid(20, "stream_timeout");
            check_instr(p);
            p = p + 8'(exp_len(p));
            tick();
        end
    endtask

    task automatic do_reset();
        resetN           = 1'b0;
        bus.redirectEn   = 1'b0;
        bus.redirectAddr = 8'h00;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic redirect_to(input logic [7:0] tgt);
        bus.redirectEn   = 1'b1;
        bus.redirectAddr = tgt;
        tick();
        bus.redirectEn   = 1'b0;
        #1;
    endtask

    initial begin
        int         base;
        int         accepted;
        logic [7:0] exp_pc;
        logic       stalled;

        bus.instrReady   = 1'b1;
        bus.redirectEn   = 1'b0;
        bus.redirectAddr = 8'h00;
        for (int a = 0; a < 256; a++) mem[a] = 8'hFF;

        vecs[0]  = '{pc: 8'h00, len: 1, b0: 8'hFF, b1: 8'h00, b2: 8'h00, npc: 8'h01};
        vecs[1]  = '{pc: 8'h01, len: 2, b0: 8'h08, b1: 8'h2A, b2: 8'h00, npc: 8'h03};
        vecs[2]  = '{pc: 8'h03, len: 3, b0: 8'h8D, b1: 8'h12, b2: 8'h34, npc: 8'h06};
        vecs[3]  = '{pc: 8'h06, len: 1, b0: 8'h0E, b1: 8'h00, b2: 8'h00, npc: 8'h07};
        vecs[4]  = '{pc: 8'h07, len: 3, b0: 8'h44, b1: 8'h55, b2: 8'h66, npc: 8'h0A};
        vecs[5]  = '{pc: 8'h0A, len: 2, b0: 8'h1C, b1: 8'h99, b2: 8'h00, npc: 8'h0C};
        vecs[6]  = '{pc: 8'h0C, len: 3, b0: 8'h3D, b1: 8'hAA, b2: 8'hBB, npc: 8'h0F};
        vecs[7]  = '{pc: 8'h0F, len: 2, b0: 8'hB0, b1: 8'hC1, b2: 8'h00, npc: 8'h11};
        vecs[8]  = '{pc: 8'h11, len: 2, b0: 8'hE3, b1: 8'hC4, b2: 8'h00, npc: 8'h13};
        vecs[9]  = '{pc: 8'h13, len: 2, b0: 8'hA9, b1: 8'hD5, b2: 8'h00, npc: 8'h15};
        vecs[10] = '{pc: 8'h15, len: 3, b0: 8'h56, b1: 8'h01, b2: 8'h02, npc: 8'h18};
        vecs[11] = '{pc: 8'h18, len: 1, b0: 8'h2F, b1: 8'h00, b2: 8'h00, npc: 8'h19};
        for (int i = 0; i < 12; i++) begin
            logic [7:0] a;
            a      = vecs[i].pc;
            mem[a] = vecs[i].b0;
            if (vecs[i].len >= 2) begin a = a + 8'd1; mem[a] = vecs[i].b1; end
            if (vecs[i].len == 3) begin a = a + 8'd1; mem[a] = vecs[i].b2; end
        end
        mem[8'h40] = 8'h45; mem[8'h41] = 8'h77; mem[8'h42] = 8'h88;
        mem[8'h43] = 8'h1C; mem[8'h44] = 8'h5A;
        for (int i = 0; i < 16; i++) mem[8'h80 + i] = {4'(i), (i % 2 == 1) ? 4'hF : 4'hE};

        // Reset values, then first-instruction latency and the vector table.
        tick();
        check("rst_valid", 32'(bus.instrValid), 32'h0);
        check("rst_strobe", 32'(bus.memStrobe), 32'h0);
        check("rst_mem_addr", 32'(bus.memAddr), 32'(RESET_PC));
        check("rst_pc", 32'(bus.instrPc), 32'(RESET_PC));
        check("rst_next_pc", 32'(bus.instrNextPc), 32'(RESET_PC));
        check("rst_byte0", 32'(bus.instrByte0), 32'h0);
        do_reset();
        #1;
        check("lat_strobe_c0", 32'(bus.memStrobe), 32'h1);
        check("lat_addr_c0", 32'(bus.memAddr), 32'(RESET_PC));
        tick();
        tick();
        check("lat_valid_c2", 32'(bus.instrValid), 32'h0);
        tick();
        check("lat_valid_c3", 32'(bus.instrValid), 32'h1);
        for (int i = 0; i < 12; i++) begin
            wait_valid(20, "vec_timeout");
            check("vec_len", 32'(bus.instrLen), vecs[i].len);
            check("vec_b0", 32'(bus.instrByte0), 32'(vecs[i].b0));
            check("vec_b1", 32'(bus.instrByte1), 32'(vecs[i].b1));
            check("vec_b2", 32'(bus.instrByte2), 32'(vecs[i].b2));
            check("vec_pc", 32'(bus.instrPc), 32'(vecs[i].pc));
            check("vec_npc", 32'(bus.instrNextPc), 32'(vecs[i].npc));
            tick();
        end

        // Stall on the first instruction: outputs hold, fetch stops at DEPTH.
        bus.instrReady = 1'b0;
        do_reset();
        base = strobes;
        wait_valid(20, "stall_timeout");
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", 32'(bus.instrValid), 32'h1);
            check("stall_pc", 32'(bus.instrPc), 32'h00);
            check("stall_b0", 32'(bus.instrByte0), 32'hFF);
            check("stall_len", 32'(bus.instrLen), 32'h1);
            tick();
        end
        check("stall_strobe_off", 32'(bus.memStrobe), 32'h0);
        check("stall_strobe_cnt", 32'(strobes - base), 32'(1 + DEPTH));
        bus.instrReady = 1'b1;
        run_stream(8'h00, 14);

        // Redirect with a byte in flight and a handshake on the same edge.
        bus.instrReady = 1'b0;
        do_reset();
        wait_valid(20, "redir_timeout");
        bus.instrReady   = 1'b1;
        bus.redirectEn   = 1'b1;
        bus.redirectAddr = 8'h40;
        #1;
        check("redir_in_flight", 32'(dut.in_flight_q), 32'h1);
        check_instr(8'h00);
        tick();
        bus.redirectEn = 1'b0;
        #1;
        check("redir_valid_low", 32'(bus.instrValid), 32'h0);
        check("redir_strobe", 32'(bus.memStrobe), 32'h1);
        check("redir_addr", 32'(bus.memAddr), 32'h40);
        run_stream(8'h40, 6);

        // Reset pulse while the 3-byte instruction at 03 is half assembled.
        redirect_to(8'h03);
        tick();
        tick();
        tick();
        resetN = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.instrValid), 32'h0);
        check("midrst_strobe", 32'(bus.memStrobe), 32'h0);
        check("midrst_mem_addr", 32'(bus.memAddr), 32'(RESET_PC));
        check("midrst_pc", 32'(bus.instrPc), 32'(RESET_PC));
        check("midrst_next_pc", 32'(bus.instrNextPc), 32'(RESET_PC));
        check("midrst_bytes", 32'({bus.instrByte0, bus.instrByte1, bus.instrByte2}), 32'h0);
        tick();
        resetN = 1'b1;
        #1;
        check("midrst_restart", 32'(bus.memAddr), 32'(RESET_PC));
        run_stream(RESET_PC, 4);

        // Back-to-back 1-byte opcodes sustain one instruction per cycle.
        redirect_to(8'h80);
        wait_valid(20, "tput_timeout");
        for (int i = 0; i < 16; i++) begin
            check("tput_valid", 32'(bus.instrValid), 32'h1);
            check("tput_pc", 32'(bus.instrPc), 32'(8'h80 + 8'(i)));
            tick();
        end

        // Address wrap across FF -> 00.
        mem[8'hFE] = 8'h0D; mem[8'hFF] = 8'h12; mem[8'h00] = 8'h34;
        redirect_to(8'hFE);
        wait_valid(20, "wrap_timeout");
        check("wrap_pc", 32'(bus.instrPc), 32'hFE);
        check("wrap_len", 32'(bus.instrLen), 32'h3);
        check("wrap_bytes", 32'({bus.instrByte0, bus.instrByte1, bus.instrByte2}), 32'h0D1234);
        check("wrap_next_pc", 32'(bus.instrNextPc), 32'h01);
        tick();
        run_stream(8'h01, 3);

        // Randomized ready/redirect traffic against the stream model.
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        do_reset();
        exp_pc   = RESET_PC;
        stalled  = 1'b0;
        accepted = 0;
        for (int c = 0; c < 3000; c++) begin
            logic       redir;
            logic [7:0] tgt;
            redir            = ($urandom_range(0, 39) == 0);
            tgt              = 8'($urandom);
            bus.instrReady   = ($urandom_range(0, 9) < 7);
            bus.redirectEn   = redir;
            bus.redirectAddr = tgt;
            #1;
            if (stalled) check("rnd_hold_valid", 32'(bus.instrValid), 32'h1);
            if (bus.instrValid) check_instr(exp_pc);
            if (bus.instrValid && bus.instrReady) begin
                exp_pc = exp_pc + 8'(exp_len(exp_pc));
                accepted++;
            end
            stalled = bus.instrValid && !bus.instrReady && !redir;
            if (redir) exp_pc = tgt;
            tick();
        end
        bus.redirectEn = 1'b0;
        check("rnd_progress", 32'(accepted > 300), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
